// File: rtl/dmi_pkg.sv
// Shared types and status codes for the DMI request sequencer.
package dmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } dmi_state_e;

    localparam logic [1:0] DMI_OK     = 2'b00;
    localparam logic [1:0] DMI_FAILED = 2'b10;
    localparam logic [1:0] DMI_BUSY   = 2'b11;

    localparam int unsigned DMI_DATA_W    = 32;
    // Widest DMI address the request struct can carry; narrower ABITS zero-extend.
    localparam int unsigned DMI_ADDR_MAXW = 16;

    typedef struct packed {
        logic                     wr;
        logic [DMI_ADDR_MAXW-1:0] addr;
        logic [DMI_DATA_W-1:0]    data;
    } dmi_req_t;

endpackage

// File: rtl/dmi_req_timer.sv
// Response timeout counter: clear on request launch, count while enabled, pulse on expiry.
module dmi_req_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th enabled cycle after the clear.
    assign expire_c = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dmi_req_ctrl.sv
// Core-clock DMI request sequencer: launches one request to the debug module, captures the
// response and keeps sticky status. Optional response timeout via DMI_REQ_TIMEOUT_EN.
module dmi_req_ctrl
    import dmi_pkg::*;
#(
    parameter int unsigned ABITS          = 7,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  DM_IDLE        = 3'd1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [ABITS-1:0] req_addr,
    input  logic [31:0]      req_data,
    input  logic             dmi_reset,
    input  logic             dmi_hard_reset,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic             dm_req_wr,
    output logic [ABITS-1:0] dm_req_addr,
    output logic [31:0]      dm_req_wdata,
    input  logic             dm_rsp_valid,
    input  logic [31:0]      dm_rsp_rdata,
    input  logic             dm_rsp_err,
    output logic [31:0]      rd_data,
    output logic [1:0]       rd_status,
    output logic [1:0]       dmi_stat,
    output logic [2:0]       idle,
    output logic             busy
);

    if (ABITS > DMI_ADDR_MAXW) begin : g_abits_chk
        $error("ABITS exceeds DMI_ADDR_MAXW");
    end

    dmi_state_e state_q, state_d;
    dmi_req_t   req_q, req_d;
    logic       dm_req_valid_q, dm_req_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [1:0] dmi_stat_q, dmi_stat_d;
    logic       accept_c;
    logic       tmo_expire_c;

    assign busy     = (state_q != ST_IDLE);
    assign accept_c = (state_q == ST_IDLE) && req_valid && (dmi_stat_q == DMI_OK) && !dmi_hard_reset;

`ifdef DMI_REQ_TIMEOUT_EN
    dmi_req_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_l    (rst_l),
        .clr      (accept_c),
        .en       (busy),
        .expire_c (tmo_expire_c)
    );
`else
    logic unused_tmo;
    assign unused_tmo   = (TIMEOUT_CYCLES == 0);
    assign tmo_expire_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response arriving with the timeout wins; ready arriving with the timeout does not.
    always_comb begin
        state_d = state_q;
        if (dmi_hard_reset) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (accept_c) state_d = ST_REQ;
                ST_REQ: begin
                    if (tmo_expire_c)      state_d = ST_IDLE;
                    else if (dm_req_ready) state_d = ST_RSP;
                end
                ST_RSP: if (dm_rsp_valid || tmo_expire_c) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_d          = req_q;
        dm_req_valid_d = dm_req_valid_q;
        rd_data_d      = rd_data_q;
        dmi_stat_d     = dmi_stat_q;
        if (dmi_hard_reset) begin
            dm_req_valid_d = 1'b0;
            dmi_stat_d     = DMI_OK;
        end else begin
            if (accept_c) begin
                req_d          = '{wr: req_wr, addr: DMI_ADDR_MAXW'(req_addr), data: req_data};
                dm_req_valid_d = 1'b1;
            end
            if (busy && req_valid && dmi_stat_q == DMI_OK) begin
                dmi_stat_d = DMI_BUSY;
            end
            if (state_q == ST_REQ && dm_req_ready) begin
                dm_req_valid_d = 1'b0;
            end
            if (state_q == ST_RSP && dm_rsp_valid) begin
                rd_data_d = dm_rsp_rdata;
                if (dm_rsp_err && dmi_stat_q == DMI_OK) dmi_stat_d = DMI_FAILED;
            end else if (tmo_expire_c) begin
                dm_req_valid_d = 1'b0;
                if (dmi_stat_q == DMI_OK) dmi_stat_d = DMI_FAILED;
            end
            // Clear beats any set in the same cycle.
            if (dmi_reset) dmi_stat_d = DMI_OK;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_q          <= '0;
            dm_req_valid_q <= 1'b0;
            rd_data_q      <= '0;
            dmi_stat_q     <= DMI_OK;
        end else begin
            req_q          <= req_d;
            dm_req_valid_q <= dm_req_valid_d;
            rd_data_q      <= rd_data_d;
            dmi_stat_q     <= dmi_stat_d;
        end
    end

    assign dm_req_valid = dm_req_valid_q;
    assign dm_req_wr    = req_q.wr;
    assign dm_req_addr  = ABITS'(req_q.addr);
    assign dm_req_wdata = req_q.data;
    assign rd_data      = rd_data_q;
    assign dmi_stat     = dmi_stat_q;
    assign rd_status    = busy ? DMI_BUSY : dmi_stat_q;
    assign idle         = DM_IDLE;

endmodule

// File: tb/tb_dmi_req_ctrl.sv
// Self-checking bench for dmi_req_ctrl: directed scenarios plus a randomized transaction-level model.
module tb_dmi_req_ctrl;

    localparam int unsigned ABITS = 7;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             req_valid, req_wr, dmi_reset, dmi_hard_reset;
    logic [ABITS-1:0] req_addr;
    logic [31:0]      req_data;
    logic             dm_req_valid, dm_req_ready, dm_req_wr;
    logic [ABITS-1:0] dm_req_addr;
    logic [31:0]      dm_req_wdata;
    logic             dm_rsp_valid, dm_rsp_err;
    logic [31:0]      dm_rsp_rdata, rd_data;
    logic [1:0]       rd_status, dmi_stat;
    logic [2:0]       idle;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_rd = 32'h0;

    dmi_req_ctrl #(.ABITS(ABITS), .TIMEOUT_CYCLES(8), .DM_IDLE(3'd1)) dut (
        .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .dmi_reset(dmi_reset),
        .dmi_hard_reset(dmi_hard_reset), .dm_req_valid(dm_req_valid),
        .dm_req_ready(dm_req_ready), .dm_req_wr(dm_req_wr), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_err(dm_rsp_err), .rd_data(rd_data),
        .rd_status(rd_status), .dmi_stat(dmi_stat), .idle(idle), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 0; dm_req_ready = 0; dm_rsp_valid = 0; dm_rsp_err = 0;
        dmi_reset = 0; dmi_hard_reset = 0;
    endtask

    task automatic issue(input logic wr, input logic [ABITS-1:0] a, input logic [31:0] d);
        req_valid = 1; req_wr = wr; req_addr = a; req_data = d;
        tick();
        req_valid = 0;
    endtask

    task automatic respond(input logic [31:0] d, input logic err);
        dm_rsp_valid = 1; dm_rsp_rdata = d; dm_rsp_err = err;
        tick();
        dm_rsp_valid = 0; dm_rsp_err = 0;
    endtask

    task automatic test_reset();
        rst_l = 0; clear_inputs();
        req_valid = 1; req_wr = 1; req_addr = 7'h55; req_data = $urandom;
        tick(); tick();
        vectors++; if ({dm_req_valid, dm_req_wr, dm_req_addr, busy} !== '0) begin miscompares++;
            $display("FAIL reset_ctrl: got v=%0b wr=%0b addr=%0h busy=%0b required 0", dm_req_valid, dm_req_wr, dm_req_addr, busy); end
        vectors++; if (dm_req_wdata !== 32'h0 || rd_data !== 32'h0) begin miscompares++;
            $display("FAIL reset_data: got wdata=%0h rd=%0h required 0", dm_req_wdata, rd_data); end
        vectors++; if (dmi_stat !== 2'b00 || rd_status !== 2'b00 || idle !== 3'd1) begin miscompares++;
            $display("FAIL reset_status: got stat=%0b rds=%0b idle=%0d required 00 00 1", dmi_stat, rd_status, idle); end
        clear_inputs();
        rst_l = 1;
        tick();
    endtask

    task automatic test_read_basic();
        issue(1'b0, 7'h11, $urandom);
        vectors++; if (dm_req_valid !== 1 || busy !== 1 || dm_req_addr !== 7'h11 || dm_req_wr !== 0 || rd_status !== 2'b11) begin miscompares++;
            $display("FAIL read_launch: got v=%0b busy=%0b addr=%0h wr=%0b rds=%0b required 1 1 11 0 11", dm_req_valid, busy, dm_req_addr, dm_req_wr, rd_status); end
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        vectors++; if (dm_req_valid !== 0 || busy !== 1) begin miscompares++;
            $display("FAIL read_accept: got v=%0b busy=%0b required 0 1", dm_req_valid, busy); end
        respond(32'hDEADBEEF, 1'b0); exp_rd = 32'hDEADBEEF;
        vectors++; if (rd_data !== 32'hDEADBEEF || rd_status !== 2'b00 || busy !== 0) begin miscompares++;
            $display("FAIL read_done: got rd=%0h rds=%0b busy=%0b required deadbeef 00 0", rd_data, rd_status, busy); end
    endtask

    task automatic test_write_wait();
        int seen = 0;
        issue(1'b1, 7'h04, 32'h12345678);
        if (dm_req_valid === 1) seen++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dm_req_valid === 1 && dm_req_addr === 7'h04 && dm_req_wdata === 32'h12345678 && dm_req_wr === 1) seen++;
        end
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        vectors++; if (seen != 6 || dm_req_valid !== 0) begin miscompares++;
            $display("FAIL write_hold: got %0d stable valid cycles, v=%0b after ready, required 6 and 0", seen, dm_req_valid); end
        exp_rd = $urandom; respond(exp_rd, 1'b0);
        vectors++; if (rd_status !== 2'b00 || rd_data !== exp_rd) begin miscompares++;
            $display("FAIL write_done: got rds=%0b rd=%0h required 00 %0h", rd_status, rd_data, exp_rd); end
    endtask

    task automatic test_overrun();
        issue(1'b0, 7'h20, 0);
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        req_valid = 1; req_addr = 7'h33; tick(); req_valid = 0;
        vectors++; if (dmi_stat !== 2'b11 || rd_status !== 2'b11) begin miscompares++;
            $display("FAIL overrun_set: got stat=%0b rds=%0b required 11 11", dmi_stat, rd_status); end
        exp_rd = $urandom; respond(exp_rd, 1'b0);
        vectors++; if (rd_status !== 2'b11 || busy !== 0 || rd_data !== exp_rd) begin miscompares++;
            $display("FAIL overrun_end: got rds=%0b busy=%0b rd=%0h required 11 0 %0h", rd_status, busy, rd_data, exp_rd); end
        issue(1'b1, 7'h40, $urandom);
        vectors++; if (dm_req_valid !== 0 || busy !== 0 || dmi_stat !== 2'b11) begin miscompares++;
            $display("FAIL overrun_drop: got v=%0b busy=%0b stat=%0b required 0 0 11", dm_req_valid, busy, dmi_stat); end
        dmi_reset = 1; tick(); dmi_reset = 0;
        vectors++; if (dmi_stat !== 2'b00 || rd_status !== 2'b00) begin miscompares++;
            $display("FAIL overrun_clear: got stat=%0b rds=%0b required 00 00", dmi_stat, rd_status); end
        issue(1'b1, 7'h41, 32'hCAFE0001);
        vectors++; if (dm_req_valid !== 1 || dm_req_addr !== 7'h41 || dm_req_wdata !== 32'hCAFE0001) begin miscompares++;
            $display("FAIL overrun_retry: got v=%0b addr=%0h wdata=%0h required 1 41 cafe0001", dm_req_valid, dm_req_addr, dm_req_wdata); end
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        exp_rd = $urandom; respond(exp_rd, 1'b0);
    endtask

    task automatic test_error_sticky();
        issue(1'b0, 7'h16, 0);
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        exp_rd = $urandom; respond(exp_rd, 1'b1);
        vectors++; if (rd_status !== 2'b10 || dmi_stat !== 2'b10 || rd_data !== exp_rd) begin miscompares++;
            $display("FAIL err_set: got rds=%0b stat=%0b rd=%0h required 10 10 %0h", rd_status, dmi_stat, rd_data, exp_rd); end
        issue(1'b0, 7'h17, 0);
        vectors++; if (busy !== 0 || dmi_stat !== 2'b10) begin miscompares++;
            $display("FAIL err_drop: got busy=%0b stat=%0b required 0 10", busy, dmi_stat); end
        dmi_reset = 1; tick(); dmi_reset = 0;
        issue(1'b0, 7'h18, 0);
        req_valid = 1; tick(); req_valid = 0;
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        exp_rd = $urandom; respond(exp_rd, 1'b1);
        vectors++; if (dmi_stat !== 2'b11) begin miscompares++;
            $display("FAIL err_first_sticks: got stat=%0b required 11", dmi_stat); end
        dmi_reset = 1; tick(); dmi_reset = 0;
        issue(1'b0, 7'h19, 0);
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        exp_rd = $urandom; dmi_reset = 1; respond(exp_rd, 1'b1); dmi_reset = 0;
        vectors++; if (dmi_stat !== 2'b00 || rd_status !== 2'b00 || rd_data !== exp_rd) begin miscompares++;
            $display("FAIL err_clear_wins: got stat=%0b rds=%0b rd=%0h required 00 00 %0h", dmi_stat, rd_status, rd_data, exp_rd); end
    endtask

    task automatic test_hard_reset();
        issue(1'b0, 7'h22, 0);
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        req_valid = 1; tick(); req_valid = 0;
        dmi_hard_reset = 1; tick(); dmi_hard_reset = 0;
        vectors++; if (busy !== 0 || dm_req_valid !== 0 || dmi_stat !== 2'b00) begin miscompares++;
            $display("FAIL hard_abort: got busy=%0b v=%0b stat=%0b required 0 0 00", busy, dm_req_valid, dmi_stat); end
        respond(32'hAAAA5555, 1'b1);
        vectors++; if (rd_data !== exp_rd || busy !== 0 || dmi_stat !== 2'b00) begin miscompares++;
            $display("FAIL hard_stale: got rd=%0h busy=%0b stat=%0b required %0h 0 00", rd_data, busy, dmi_stat, exp_rd); end
        issue(1'b1, 7'h23, $urandom);
        dmi_hard_reset = 1; tick(); dmi_hard_reset = 0;
        vectors++; if (dm_req_valid !== 0 || busy !== 0) begin miscompares++;
            $display("FAIL hard_in_req: got v=%0b busy=%0b required 0 0", dm_req_valid, busy); end
        dmi_hard_reset = 1; req_valid = 1; tick(); clear_inputs();
        vectors++; if (busy !== 0 || dm_req_valid !== 0) begin miscompares++;
            $display("FAIL hard_priority: got busy=%0b v=%0b required 0 0", busy, dm_req_valid); end
    endtask

    // Transaction-level model: sticky status follows first-event-wins, cleared by dmi_reset.
    task automatic test_random();
        logic [1:0] m_stat = 2'b00;
        for (int t = 0; t < 40; t++) begin
            logic             wr  = 1'($urandom);
            logic [ABITS-1:0] a   = ABITS'($urandom);
            logic [31:0]      d   = $urandom;
            logic [31:0]      r   = $urandom;
            logic             err = ($urandom_range(0, 2) == 0);
            int               w   = $urandom_range(0, 3);
            int               dl  = $urandom_range(0, 2);
            logic             ok  = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                dmi_reset = 1; tick(); dmi_reset = 0; m_stat = 2'b00;
            end
            issue(wr, a, d);
            if (m_stat != 2'b00) begin
                vectors++; if (busy !== 0 || dm_req_valid !== 0 || dmi_stat !== m_stat) begin miscompares++;
                    $display("FAIL rnd_drop t=%0d: got busy=%0b stat=%0b required 0 %0b", t, busy, dmi_stat, m_stat); end
                continue;
            end
            vectors++; if (dm_req_valid !== 1 || dm_req_wr !== wr || dm_req_addr !== a || dm_req_wdata !== d) begin miscompares++;
                $display("FAIL rnd_launch t=%0d: got v=%0b wr=%0b addr=%0h wd=%0h required 1 %0b %0h %0h", t, dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata, wr, a, d); end
            for (int i = 0; i < w; i++) begin
                req_valid = ($urandom_range(0, 3) == 0);
                if (req_valid && m_stat == 2'b00) m_stat = 2'b11;
                tick(); req_valid = 0;
                if (dm_req_valid !== 1 || dm_req_addr !== a || dm_req_wdata !== d || rd_status !== 2'b11) ok = 1'b0;
            end
            dm_req_ready = 1; tick(); dm_req_ready = 0;
            if (dm_req_valid !== 0 || busy !== 1) ok = 1'b0;
            for (int i = 0; i < dl; i++) begin
                req_valid = ($urandom_range(0, 3) == 0);
                if (req_valid && m_stat == 2'b00) m_stat = 2'b11;
                tick(); req_valid = 0;
            end
            respond(r, err);
            exp_rd = r;
            if (err && m_stat == 2'b00) m_stat = 2'b10;
            vectors++; if (!ok || rd_data !== exp_rd || dmi_stat !== m_stat || rd_status !== m_stat || busy !== 0) begin miscompares++;
                $display("FAIL rnd_done t=%0d: got hold_ok=%0b rd=%0h stat=%0b rds=%0b busy=%0b required 1 %0h %0b %0b 0", t, ok, rd_data, dmi_stat, rd_status, busy, exp_rd, m_stat, m_stat); end
        end
        dmi_reset = 1; tick(); dmi_reset = 0;
    endtask

`ifdef DMI_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int held = 0;
        issue(1'b0, 7'h30, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (busy === 1) held++;
        end
        tick();
        vectors++; if (held != 7 || busy !== 0 || dm_req_valid !== 0 || dmi_stat !== 2'b10 || rd_data !== exp_rd) begin miscompares++;
            $display("FAIL timeout_fire: got held=%0d busy=%0b v=%0b stat=%0b rd=%0h required 7 0 0 10 %0h", held, busy, dm_req_valid, dmi_stat, rd_data, exp_rd); end
        dmi_reset = 1; tick(); dmi_reset = 0;
        issue(1'b0, 7'h31, 0);
        dm_req_ready = 1; tick(); dm_req_ready = 0;
        for (int i = 0; i < 6; i++) tick();
        exp_rd = $urandom; respond(exp_rd, 1'b0);
        vectors++; if (rd_status !== 2'b00 || rd_data !== exp_rd || busy !== 0) begin miscompares++;
            $display("FAIL timeout_rsp_wins: got rds=%0b rd=%0h busy=%0b required 00 %0h 0", rd_status, rd_data, busy, exp_rd); end
    endtask
`endif

    task automatic test_async_reset();
        issue(1'b1, 7'h7F, 32'hFFFF0000);
        #2 rst_l = 0;
        #1;
        vectors++; if (dm_req_valid !== 0 || busy !== 0 || dm_req_addr !== '0 || rd_data !== 32'h0 || rd_status !== 2'b00) begin miscompares++;
            $display("FAIL async_reset: got v=%0b busy=%0b addr=%0h rd=%0h rds=%0b required all 0", dm_req_valid, busy, dm_req_addr, rd_data, rd_status); end
        tick();
        rst_l = 1;
        tick();
    endtask

    initial begin
        req_wr = 0; req_addr = '0; req_data = '0; dm_rsp_rdata = '0;
        test_reset();
        test_read_basic();
        test_write_wait();
        test_overrun();
        test_error_sticky();
        test_hard_reset();
        test_random();
`ifdef DMI_REQ_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmi_req_ctrl.md
# dmi_req_ctrl

Core-clock sequencer between the JTAG DMI capture path and the debug module. It accepts one synchronized DMI request pulse at a time and drives it to the debug module over a valid/ready handshake. It captures the response and maintains the busy and sticky-error status that the TAP reports back on `rd_status` / `dmi_stat`. It also executes `dmireset` and `dmihardreset`.

## Interface
Parameters:
- `ABITS`, 7: DMI address width.
- `TIMEOUT_CYCLES`, 256: response timeout in clk cycles (used only with the timeout macro).
- `DM_IDLE`, 3'd1: run-test-idle hint reported to the TAP.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock.
- `rst_l` in 1: asynchronous active-low reset.
- `req_valid` in 1: one-cycle request pulse, already synchronized to clk.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in ABITS: DMI register address.
- `req_data` in 32: write data.
- `dmi_reset` in 1: pulse that clears sticky status.
- `dmi_hard_reset` in 1: pulse that aborts everything.
- `dm_req_valid` out 1: request to the debug module.
- `dm_req_ready` in 1: debug module accepts the request.
- `dm_req_wr` out 1: registered copy of `req_wr`.
- `dm_req_addr` out ABITS: registered copy of `req_addr`.
- `dm_req_wdata` out 32: registered copy of `req_data`.
- `dm_rsp_valid` in 1: one-cycle response pulse.
- `dm_rsp_rdata` in 32: response data.
- `dm_rsp_err` in 1: debug module error.
- `rd_data` out 32: last captured response data.
- `rd_status` out 2: status returned to the TAP.
- `dmi_stat` out 2: sticky status.
- `idle` out 3: constant `DM_IDLE`.
- `busy` out 1: state is not IDLE.

## Operation
- Status codes: 2'b00 ok, 2'b10 failed, 2'b11 busy.
- States:
  - IDLE: no transaction. `req_valid` with `dmi_stat==0` latches `req_*` into the `dm_req_*` registers and moves to REQ.
  - REQ: `dm_req_valid=1`. Address and data are held stable. `dm_req_ready` moves to RSP.
  - RSP: `dm_rsp_valid` loads `rd_data <= dm_rsp_rdata` (for writes as well) and moves to IDLE. If `dm_rsp_err`, `dmi_stat <= 2'b10` when `dmi_stat==0`.
- `req_valid` while not IDLE is dropped; `dmi_stat <= 2'b11` if it is 0.
- `req_valid` while `dmi_stat!=0` is dropped with no change. The first error sticks until `dmi_reset`.
- `rd_status` is 2'b11 while `busy`, otherwise `dmi_stat`.
- `dmi_reset` clears `dmi_stat` and does not disturb the state. A clear in the same cycle as a set: the clear wins.
- `dmi_hard_reset` forces IDLE, deasserts `dm_req_valid` the next cycle and clears `dmi_stat`. It has priority over every other event in the same cycle.
- `dm_rsp_valid` while in IDLE or REQ is ignored, including a stale response after a hard reset.

## Timing
- All outputs are registered except `rd_status`, `busy` and `idle`, which are decoded from registers.
- Reset values: state IDLE, `dm_req_valid=0`, `dm_req_wr=0`, `dm_req_addr=0`, `dm_req_wdata=0`, `rd_data=0`, `dmi_stat=0`, `rd_status=0`, `busy=0`, `idle=DM_IDLE`.
- `req_valid` in cycle N → `dm_req_valid=1` and `busy=1` in N+1.
- `dm_req_ready` sampled high in REQ → RSP in the next cycle. Ready and response in the same cycle is not supported; the debug module responds at least one cycle after accept.
- `dm_rsp_valid` in cycle M → `rd_data` updated, `busy=0` and `rd_status` valid in M+1.
- Minimum turnaround: 3 cycles from `req_valid` to IDLE with zero-wait ready and response.
- Reset asserted mid-transaction returns immediately to the reset values.

## Configuration
- `DMI_REQ_TIMEOUT_EN` defined: a cycle counter is cleared on entry to REQ and counts in REQ and RSP.
  - When it reaches `TIMEOUT_CYCLES`: state → IDLE, `dm_req_valid=0`, `dmi_stat <= 2'b10` if 0, `rd_data` unchanged.
  - `dm_rsp_valid` in the same cycle as the timeout wins.
- Undefined: no counter; the controller waits indefinitely, and only `dmi_hard_reset` or `rst_l` recovers.

## Structure
- `dmi_pkg` holds:
  - the state enum (IDLE/REQ/RSP);
  - the status localparams `DMI_OK`, `DMI_FAILED`, `DMI_BUSY`;
  - the request struct {wr, addr, data}.
- One sub-module, `dmi_req_timer`: the counter with clear, enable and expiry pulse. It is instantiated only under `DMI_REQ_TIMEOUT_EN`.

## Test plan
- Read 0x11 with ready and response each one cycle after the prior step, rdata 0xDEADBEEF → `dm_req_addr=0x11`, `dm_req_wr=0`, `rd_data=0xDEADBEEF`, `rd_status=00`, `busy` low 3 cycles after `req_valid`.
- Write 0x04/0x12345678 with ready held low 5 cycles → `dm_req_valid` held 6 cycles with stable addr/data; then `rd_status=00`.
- Second `req_valid` during RSP → `dmi_stat=11`. Next request is ignored with no `dm_req_valid`. `dmi_reset` → `dmi_stat=00`, and a following request proceeds.
- Response with `dm_rsp_err=1` → `rd_status=10`, `dmi_stat=10`. A later error keeps 10. `dmi_reset` coincident with an error → 00.
- `dmi_hard_reset` in RSP, then a stale `dm_rsp_valid` with 0xAAAA5555 → IDLE, `rd_data` unchanged, `dmi_stat=00`.
- With `DMI_REQ_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, no response → IDLE and `dmi_stat=10` after 8 cycles. Response on cycle 8 → `rd_status=00`.
